// File: rtl/wb_host_master.sv
// wb_host_master
// Wishbone classic single-transfer initiator. Accepts one command at a time
// from a valid/ready stream, runs one read or write on the wbm_* port, and
// returns the result (read data or a timeout error) on a valid/ready
// response stream. Timed-out transfers are tallied in a saturating counter.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   cmd_valid/cmd_ready   command handshake; cmd_we/adr/dat/sel payload
//   rsp_valid/rsp_ready   response handshake; rsp_dat/rsp_err payload
//   wbm_*                 Wishbone classic master signals
//   busy                  high whenever a command is being processed
//   err_count             saturating count of timeout aborts since reset
module wb_host_master #(
  parameter  int ADR_W    = 32,
  parameter  int DAT_W    = 32,
  parameter  int TIMEOUT  = 256,
  parameter  int ERRCNT_W = 8,
  localparam int SEL_W    = DAT_W / 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_we,
  input  logic [ADR_W-1:0]    cmd_adr,
  input  logic [DAT_W-1:0]    cmd_dat,
  input  logic [SEL_W-1:0]    cmd_sel,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DAT_W-1:0]    rsp_dat,
  output logic                rsp_err,
  output logic                wbm_cyc_o,
  output logic                wbm_stb_o,
  output logic                wbm_we_o,
  output logic [SEL_W-1:0]    wbm_sel_o,
  output logic [ADR_W-1:0]    wbm_adr_o,
  output logic [DAT_W-1:0]    wbm_dat_o,
  input  logic [DAT_W-1:0]    wbm_dat_i,
  input  logic                wbm_ack_i,
  output logic                busy,
  output logic [ERRCNT_W-1:0] err_count
);

  // Counter only needs to reach TIMEOUT-1: the abort fires on the edge that
  // ends the TIMEOUT-th STB cycle, when the count still reads TIMEOUT-1.
  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t              state_r,   state_s;
  logic                cyc_r,     cyc_s;
  logic                we_r,      we_s;
  logic [SEL_W-1:0]    sel_r,     sel_s;
  logic [ADR_W-1:0]    adr_r,     adr_s;
  logic [DAT_W-1:0]    dat_r,     dat_s;
  logic                rvalid_r,  rvalid_s;
  logic [DAT_W-1:0]    rdat_r,    rdat_s;
  logic                rerr_r,    rerr_s;
  logic [ERRCNT_W-1:0] errcnt_r,  errcnt_s;
  logic [CNT_W-1:0]    tmo_cnt_r, tmo_cnt_s;

  function automatic logic [ERRCNT_W-1:0] sat_inc(input logic [ERRCNT_W-1:0] v);
    if (v == {ERRCNT_W{1'b1}}) begin
      sat_inc = v;
    end else begin
      sat_inc = v + ERRCNT_W'(1);
    end
  endfunction

  // Next-state and next-output logic for the transfer FSM.
  always_comb begin
    state_s   = state_r;
    cyc_s     = cyc_r;
    we_s      = we_r;
    sel_s     = sel_r;
    adr_s     = adr_r;
    dat_s     = dat_r;
    rvalid_s  = rvalid_r;
    rdat_s    = rdat_r;
    rerr_s    = rerr_r;
    errcnt_s  = errcnt_r;
    tmo_cnt_s = tmo_cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (cmd_valid) begin
          state_s   = ST_BUS;
          cyc_s     = 1'b1;
          we_s      = cmd_we;
          sel_s     = cmd_sel;
          adr_s     = cmd_adr;
          dat_s     = cmd_dat;
          tmo_cnt_s = {CNT_W{1'b0}};
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_BUS: begin
        // ACK has priority over the timeout on the final cycle.
        if (wbm_ack_i) begin
          state_s  = ST_RESP;
          cyc_s    = 1'b0;
          we_s     = 1'b0;
          sel_s    = {SEL_W{1'b0}};
          rvalid_s = 1'b1;
          rerr_s   = 1'b0;
          rdat_s   = we_r ? {DAT_W{1'b0}} : wbm_dat_i;
        end else if (tmo_cnt_r == CNT_LAST) begin
          state_s  = ST_RESP;
          cyc_s    = 1'b0;
          we_s     = 1'b0;
          sel_s    = {SEL_W{1'b0}};
          rvalid_s = 1'b1;
          rerr_s   = 1'b1;
          rdat_s   = {DAT_W{1'b0}};
          errcnt_s = sat_inc(errcnt_r);
        end else begin
          tmo_cnt_s = tmo_cnt_r + CNT_W'(1);
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_s  = ST_IDLE;
          rvalid_s = 1'b0;
        end else begin
          state_s = ST_RESP;
        end
      end
      default: begin
        state_s  = ST_IDLE;
        cyc_s    = 1'b0;
        we_s     = 1'b0;
        sel_s    = {SEL_W{1'b0}};
        rvalid_s = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      cyc_r     <= 1'b0;
      we_r      <= 1'b0;
      sel_r     <= {SEL_W{1'b0}};
      adr_r     <= {ADR_W{1'b0}};
      dat_r     <= {DAT_W{1'b0}};
      rvalid_r  <= 1'b0;
      rdat_r    <= {DAT_W{1'b0}};
      rerr_r    <= 1'b0;
      errcnt_r  <= {ERRCNT_W{1'b0}};
      tmo_cnt_r <= {CNT_W{1'b0}};
    end else begin
      state_r   <= state_s;
      cyc_r     <= cyc_s;
      we_r      <= we_s;
      sel_r     <= sel_s;
      adr_r     <= adr_s;
      dat_r     <= dat_s;
      rvalid_r  <= rvalid_s;
      rdat_r    <= rdat_s;
      rerr_r    <= rerr_s;
      errcnt_r  <= errcnt_s;
      tmo_cnt_r <= tmo_cnt_s;
    end
  end

  // CYC and STB are identical for single classic transfers.
  assign wbm_cyc_o = cyc_r;
  assign wbm_stb_o = cyc_r;
  assign wbm_we_o  = we_r;
  assign wbm_sel_o = sel_r;
  assign wbm_adr_o = adr_r;
  assign wbm_dat_o = dat_r;
  assign rsp_valid = rvalid_r;
  assign rsp_dat   = rdat_r;
  assign rsp_err   = rerr_r;
  assign err_count = errcnt_r;
  assign cmd_ready = (state_r == ST_IDLE);
  assign busy      = (state_r != ST_IDLE);

endmodule

// File: tb/tb_wb_host_master.sv
module tb_wb_host_master;
  localparam int ADR_W    = 32;
  localparam int DAT_W    = 32;
  localparam int SEL_W    = 4;
  localparam int TIMEOUT  = 8;
  localparam int ERRCNT_W = 8;
  localparam int ERR_MAX  = (1 << ERRCNT_W) - 1;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                cmd_valid, cmd_ready, cmd_we;
  logic [ADR_W-1:0]    cmd_adr;
  logic [DAT_W-1:0]    cmd_dat;
  logic [SEL_W-1:0]    cmd_sel;
  logic                rsp_valid, rsp_ready, rsp_err;
  logic [DAT_W-1:0]    rsp_dat;
  logic                wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [SEL_W-1:0]    wbm_sel_o;
  logic [ADR_W-1:0]    wbm_adr_o;
  logic [DAT_W-1:0]    wbm_dat_o;
  logic [DAT_W-1:0]    wbm_dat_i = '0;
  logic                wbm_ack_i = 1'b0;
  logic                busy;
  logic [ERRCNT_W-1:0] err_count;

  wb_host_master #(.ADR_W(ADR_W), .DAT_W(DAT_W), .TIMEOUT(TIMEOUT), .ERRCNT_W(ERRCNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_adr(cmd_adr), .cmd_dat(cmd_dat), .cmd_sel(cmd_sel),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat), .rsp_err(rsp_err),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
    .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
    .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i),
    .busy(busy), .err_count(err_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Slave plan per transfer: ACK on the n-th STB cycle (0 = never), read data.
  int          plan_delay[$];
  logic [31:0] plan_rdata[$];
  bit          stray_en = 1'b0;

  // Transaction-level reference: one outstanding command, STB length bounded
  // by TIMEOUT, response held until consumed, saturating timeout tally.
  bit          m_stb = 1'b0, m_rv = 1'b0, m_rerr = 1'b0;
  int          m_cnt = 0, m_err = 0;
  logic        m_we = 1'b0;
  logic [31:0] m_adr = '0, m_dat = '0, m_rdat = '0;
  logic [3:0]  m_sel = '0;

  // Observations used by the hand-computed expectations.
  int cyc_n = 0, acc_cyc = 0, rsp_rise_cyc = 0, last_rise = -1, min_gap = 1000;
  int rise_cnt = 0, run_len = 0, last_stb_len = 0;
  bit prev_stb = 1'b0, prev_rv = 1'b0;
  int sc = 0, cur_delay = 1;
  logic [31:0] cur_rdata = '0;

  // Compare, slave response, then model advance across the coming edge.
  always @(negedge clk) begin
    check("cmd_ready", 64'(cmd_ready), 64'(!(m_stb || m_rv)));
    check("busy",      64'(busy),      64'(m_stb || m_rv));
    check("cyc",       64'(wbm_cyc_o), 64'(m_stb));
    check("stb",       64'(wbm_stb_o), 64'(m_stb));
    check("we",        64'(wbm_we_o),  64'(m_stb ? m_we : 1'b0));
    check("sel",       64'(wbm_sel_o), 64'(m_stb ? m_sel : 4'h0));
    check("adr",       64'(wbm_adr_o), 64'(m_adr));
    check("dat_o",     64'(wbm_dat_o), 64'(m_dat));
    check("rsp_valid", 64'(rsp_valid), 64'(m_rv));
    check("err_count", 64'(err_count), 64'(m_err));
    if (m_rv) begin
      check("rsp_dat", 64'(rsp_dat), 64'(m_rdat));
      check("rsp_err", 64'(rsp_err), 64'(m_rerr));
    end

    if (wbm_stb_o) begin
      run_len++;
      if (!prev_stb) begin
        rise_cnt++;
        if (last_rise >= 0 && (cyc_n - last_rise) < min_gap) min_gap = cyc_n - last_rise;
        last_rise = cyc_n;
      end
    end else if (prev_stb) begin
      last_stb_len = run_len;
      run_len = 0;
    end
    if (rsp_valid && !prev_rv) rsp_rise_cyc = cyc_n;
    prev_stb = wbm_stb_o;
    prev_rv  = rsp_valid;

    if (wbm_stb_o) begin
      sc++;
      if (sc == 1) begin
        if (plan_delay.size() > 0) begin
          cur_delay = plan_delay.pop_front();
          cur_rdata = plan_rdata.pop_front();
        end else begin
          cur_delay = 1;
          cur_rdata = $urandom;
        end
      end
      wbm_ack_i = (sc == cur_delay);
      wbm_dat_i = wbm_ack_i ? cur_rdata : $urandom;
    end else begin
      sc = 0;
      wbm_ack_i = stray_en && ($urandom_range(0, 1) == 1);
      wbm_dat_i = $urandom;
    end

    if (!rst_n) begin
      m_stb = 1'b0; m_rv = 1'b0; m_rerr = 1'b0; m_rdat = '0; m_err = 0;
      m_we = 1'b0; m_sel = '0; m_adr = '0; m_dat = '0;
    end else if (m_rv) begin
      if (rsp_ready) m_rv = 1'b0;
    end else if (m_stb) begin
      m_cnt++;
      if (wbm_ack_i) begin
        m_stb = 1'b0; m_rv = 1'b1; m_rerr = 1'b0;
        m_rdat = m_we ? 32'h0 : wbm_dat_i;
      end else if (m_cnt == TIMEOUT) begin
        m_stb = 1'b0; m_rv = 1'b1; m_rerr = 1'b1; m_rdat = 32'h0;
        if (m_err < ERR_MAX) m_err++;
      end
    end else if (cmd_valid) begin
      m_stb = 1'b1; m_cnt = 0; acc_cyc = cyc_n;
      m_we = cmd_we; m_adr = cmd_adr; m_dat = cmd_dat; m_sel = cmd_sel;
    end
    cyc_n++;
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                      input logic [3:0] sel, input int delay, input logic [31:0] rdata,
                      input bit keep);
    int n;
    plan_delay.push_back(delay);
    plan_rdata.push_back(rdata);
    cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel; cmd_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) check("accept_wait", 64'(0), 64'(1));
    @(posedge clk); #1;
    if (!keep) cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rsp_valid && n < 400);
    if (!rsp_valid) check("rsp_wait", 64'(0), 64'(1));
    #1;
  endtask

  task automatic wait_idle(input bit rnd);
    int n;
    n = 0;
    do begin
      @(posedge clk); #1;
      if (rnd) rsp_ready = ($urandom_range(0, 2) != 0);
      n++;
    end while (busy && n < 400);
    if (busy) check("idle_wait", 64'(0), 64'(1));
    rsp_ready = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0;
    cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_dat = '0; cmd_sel = '0;
    rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_cyc",  64'(wbm_cyc_o), 64'(0));
    check("rst_rv",   64'(rsp_valid), 64'(0));
    check("rst_err",  64'(err_count), 64'(0));
    check("rst_rdy",  64'(cmd_ready), 64'(1));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Write, ACK on second STB cycle.
    send(1'b1, 32'h3000_0004, 32'hDEAD_BEEF, 4'hF, 2, 32'h0, 1'b0);
    wait_rsp();
    check("wr_stb_len", 64'(last_stb_len), 64'(2));
    check("wr_rsp_err", 64'(rsp_err), 64'(0));
    check("wr_rsp_dat", 64'(rsp_dat), 64'(0));
    wait_idle(1'b0);

    // Read, ACK on first cycle, response held while rsp_ready is low.
    rsp_ready = 1'b0;
    send(1'b0, 32'h3000_0010, $urandom, 4'hF, 1, 32'h0000_00A5, 1'b0);
    wait_rsp();
    check("rd_latency", 64'(rsp_rise_cyc - acc_cyc), 64'(2));
    check("rd_rsp_dat", 64'(rsp_dat), 64'h0000_00A5);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rd_hold_v", 64'(rsp_valid), 64'(1));
      check("rd_hold_d", 64'(rsp_dat), 64'h0000_00A5);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("rd_release", 64'(rsp_valid), 64'(0));
    @(posedge clk); #1;

    // Timeout with no ACK.
    send(1'b0, 32'h3000_0020, 32'h0, 4'h3, 0, 32'h0, 1'b0);
    wait_rsp();
    check("to_stb_len", 64'(last_stb_len), 64'(TIMEOUT));
    check("to_rsp_err", 64'(rsp_err), 64'(1));
    check("to_rsp_dat", 64'(rsp_dat), 64'(0));
    check("to_errcnt",  64'(err_count), 64'(1));
    wait_idle(1'b0);

    // ACK on the final cycle wins.
    send(1'b0, 32'h3000_0024, 32'h0, 4'hF, TIMEOUT, 32'h1234_5678, 1'b0);
    wait_rsp();
    check("last_stb_len", 64'(last_stb_len), 64'(TIMEOUT));
    check("last_rsp_err", 64'(rsp_err), 64'(0));
    check("last_rsp_dat", 64'(rsp_dat), 64'h1234_5678);
    check("last_errcnt",  64'(err_count), 64'(1));
    wait_idle(1'b0);

    // Randomized mix with stray ACKs and random response back-pressure.
    stray_en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      send(1'($urandom), $urandom, $urandom, 4'($urandom), $urandom_range(0, TIMEOUT + 2),
           $urandom, 1'b0);
      wait_idle(1'b1);
    end

    // Back-to-back queued commands, stray ACKs still enabled.
    min_gap = 1000;
    r0 = rise_cnt;
    for (int i = 0; i < 4; i++) begin
      send(1'(i % 2), 32'h4000_0000 + 32'(i * 4), 32'h1111_0000 + 32'(i), 4'hF, 1,
           32'hC0DE_0000 + 32'(i), (i < 3));
    end
    wait_idle(1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("b2b_rises", 64'(rise_cnt - r0), 64'(4));
    check("b2b_gap",   64'(min_gap), 64'(3));
    stray_en = 1'b0;

    // Reset while STB is high.
    send(1'b1, 32'h3000_0030, 32'hCAFE_F00D, 4'hF, 0, 32'h0, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_rst_stb",  64'(wbm_stb_o), 64'(0));
    check("mid_rst_busy", 64'(busy), 64'(0));
    check("mid_rst_rv",   64'(rsp_valid), 64'(0));
    check("mid_rst_err",  64'(err_count), 64'(0));
    @(posedge clk); #1;
    send(1'b0, 32'h3000_0034, 32'h0, 4'hF, 1, 32'h5A5A_5A5A, 1'b0);
    wait_rsp();
    check("post_rst_err", 64'(rsp_err), 64'(0));
    check("post_rst_dat", 64'(rsp_dat), 64'h5A5A_5A5A);
    wait_idle(1'b0);

    // Saturation of the error counter.
    for (int i = 0; i < 300; i++) begin
      send(1'b0, $urandom, 32'h0, 4'hF, 0, 32'h0, 1'b0);
      wait_rsp();
      if (i == 0) check("sat_first", 64'(err_count), 64'(1));
      wait_idle(1'b0);
    end
    check("sat_errcnt", 64'(err_count), 64'(255));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_host_master.md
Name: wb_host_master

Overview:
- Wishbone classic single-transfer initiator that drives the neuron_core slave port (`wbs_*`) from an on-chip command source, e.g. a spike/weight loader or test sequencer.
- Converts a valid/ready command stream into one Wishbone read or write at a time.
- Returns read data or a timeout error on a valid/ready response stream.
- Counts aborted transfers for debug.

Parameters:
- ADR_W, 32, Wishbone address width.
- DAT_W, 32, Wishbone data width; SEL_W = DAT_W/8.
- TIMEOUT, 256, maximum cycles STB may stay high without ACK before the transfer is aborted (≥2).
- ERRCNT_W, 8, width of the saturating error counter.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready.
- cmd_we  in  1  1 = write, 0 = read.
- cmd_adr  in  ADR_W  target address.
- cmd_dat  in  DAT_W  write data.
- cmd_sel  in  SEL_W  byte selects.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed when rsp_valid & rsp_ready.
- rsp_dat  out  DAT_W  read data; 0 for writes and errors.
- rsp_err  out  1  1 = timeout abort.
- wbm_cyc_o  out  1  Wishbone CYC.
- wbm_stb_o  out  1  Wishbone STB.
- wbm_we_o  out  1  Wishbone WE.
- wbm_sel_o  out  SEL_W  Wishbone SEL.
- wbm_adr_o  out  ADR_W  Wishbone ADR.
- wbm_dat_o  out  DAT_W  Wishbone write data.
- wbm_dat_i  in  DAT_W  Wishbone read data.
- wbm_ack_i  in  1  Wishbone ACK.
- busy  out  1  state != IDLE.
- err_count  out  ERRCNT_W  number of timeouts since reset, saturating at all-ones.

Behaviour:
- Reset (rst_n sampled low at a rising edge):
  - state = IDLE; all wbm_* outputs = 0.
  - rsp_valid = 0, rsp_dat = 0, rsp_err = 0, err_count = 0, timeout counter = 0.
  - Applies mid-transfer too: CYC/STB drop after that edge, any pending response is discarded, and no error is counted.
- FSM states: IDLE, BUS, RESP.
- IDLE:
  - cmd_ready = 1 (combinational, = state==IDLE).
  - On accept at edge N: register we/adr/dat/sel onto wbm_*, set CYC = STB = 1 after edge N, clear the timeout counter, go to BUS.
- BUS:
  - cmd_ready = 0. CYC/STB/WE/ADR/SEL/DAT_O held stable; the counter increments every cycle.
  - ACK sampled high at edge M:
    - CYC = STB = 0 after M.
    - rsp_dat = wbm_dat_i for reads, 0 for writes; rsp_err = 0.
    - rsp_valid = 1 after M; go to RESP.
  - If STB has been high for TIMEOUT cycles with no ACK: on the edge ending the TIMEOUT-th cycle, drop CYC/STB, set rsp_err = 1, rsp_dat = 0, rsp_valid = 1, increment err_count (saturating), go to RESP.
  - ACK on that same final cycle wins: normal completion, no error.
- RESP:
  - rsp_valid = 1 with rsp_dat/rsp_err held stable until rsp_ready is sampled high.
  - Then rsp_valid = 0 and state returns to IDLE. The next command can be accepted in the IDLE cycle that follows.
  - Minimum spacing between STB assertions is 3 cycles.
- Stray ACK (IDLE or RESP): ignored; no state or output change.
- Latency: read with ACK on the first STB cycle → rsp_valid two cycles after the cmd accept edge.
- wbm_adr_o/wbm_dat_o keep their last value outside BUS. WE/SEL return to 0 when CYC drops.
- Exactly one outstanding transfer; no pipelining and no burst (CTI/BTE not driven).

Test Plan:
- Write: cmd_we=1, adr=0x3000_0004, dat=0xDEAD_BEEF, sel=0xF; slave ACKs on the 2nd STB cycle → STB high exactly 2 cycles with stable fields; rsp_valid, rsp_err=0, rsp_dat=0.
- Read: adr=0x3000_0010; slave returns 0x0000_00A5 with ACK on the 1st cycle → rsp_dat=0x0000_00A5 one cycle after ACK; rsp_valid held 5 cycles with rsp_ready=0; then released.
- Timeout: TIMEOUT=8, slave never ACKs → STB high exactly 8 cycles; rsp_err=1, rsp_dat=0, err_count=1. Repeat 300 times with ERRCNT_W=8 → err_count saturates at 255.
- ACK on the 8th (final) cycle with TIMEOUT=8 → normal completion, rsp_err=0, err_count unchanged.
- Back-to-back: 4 queued commands with cmd_valid held and rsp_ready=1 → four single transfers in order, cmd_ready only in IDLE, STB rises ≥3 cycles apart; stray ACK in IDLE causes no response.
- Reset: rst_n low for one cycle while in BUS (STB high) → CYC/STB=0 and busy=0 after that edge; no rsp_valid; err_count=0; the next command completes normally.
